bday_seq_detector: RTL and testbench

//  Receive-side counterpart of the birthday digit generator: consumes a stream of 4-bit

---
 rtl/bday_pkg.sv | 35 +++
 rtl/bday_kmp_step.sv | 39 +++
 rtl/bday_seq_detector.sv | 105 ++++++++++
 tb/tb_bday_seq_detector.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bday_pkg.sv
// Shared types, the default birthday digit sequence and the KMP fallback-table builder.
// No logic; constants are evaluated at elaboration.
// No flow control.
package bday_pkg;

  localparam int MAX_LEN = 16;

  typedef logic [3:0] digit_t;
  // Entry [0] is the first digit of the sequence.
  typedef digit_t [MAX_LEN-1:0] seq_t;
  // Entry [k] is the fallback length for a partial match of length k (0..MAX_LEN).
  typedef logic [MAX_LEN:0][4:0] fail_t;

  localparam digit_t DIGIT_MAX = 4'd9;

  // 2,0,0,2,0,9,1,5 packed with the first digit in the lowest nibble.
  localparam seq_t BDAY_SEQ = {32'h0, 4'd5, 4'd1, 4'd9, 4'd0, 4'd2, 4'd0, 4'd0, 4'd2};

  // fail[k] = length of the longest proper prefix of seq[0..k-1] that is also its suffix.
  function automatic fail_t bday_fail_table(input seq_t seq, input int len);
    fail_t f;
    int    k;
    f = '0;
    k = 0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (i < len) begin
        while (k > 0 && seq[i] != seq[k]) k = int'(f[k]);
        if (seq[i] == seq[k]) k = k + 1;
        f[i+1] = k[4:0];
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/bday_kmp_step.sv
// One KMP step: given current match length p and digit d, produce the next length and a hit flag.
// Purely combinational, zero latency; the fallback chain is unrolled SEQ_LEN times.
// No flow control; the caller decides whether the result is used.
module bday_kmp_step
  import bday_pkg::*;
#(
  parameter int   SEQ_LEN = 8,
  parameter seq_t SEQ     = BDAY_SEQ,
  localparam int  PW      = $clog2(SEQ_LEN + 1)
) (
  input  logic [PW-1:0] p,
  input  logic [3:0]    d,
  output logic [PW-1:0] next_p,
  output logic          hit
);

  localparam fail_t FAIL = bday_fail_table(SEQ, SEQ_LEN);

  logic [3:0] pi;
  logic [4:0] adv;
  logic       done;

  // Fall back until d extends the prefix or p hits 0, then advance; a full match reloads FAIL[SEQ_LEN].
  always_comb begin
    pi   = 4'(p);
    done = 1'b0;
    // Each fallback strictly shrinks pi, so SEQ_LEN iterations always settle.
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (!done) begin
        if (pi == 4'd0 || d == SEQ[pi]) done = 1'b1;
        else                            pi   = 4'(FAIL[5'(pi)]);
      end
    end
    adv    = (d == SEQ[pi]) ? 5'(pi) + 5'd1 : 5'(pi);
    hit    = (adv == 5'(SEQ_LEN));
    next_p = hit ? PW'(FAIL[SEQ_LEN]) : PW'(adv);
  end

endmodule

// File: rtl/bday_seq_detector.sv
// Overlapping detector for the programmed birthday digit sequence, with saturating match counter.
// 1 cycle from the accepted digit to registered outputs; accepts a digit every cycle.
// No backpressure; optional idle timeout when BDAY_TIMEOUT_EN is defined.
module bday_seq_detector
  import bday_pkg::*;
#(
  parameter int   SEQ_LEN     = 8,
  parameter seq_t SEQ         = BDAY_SEQ,
  parameter int   CNT_W       = 8,
  parameter int   TIMEOUT_CYC = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         digit_valid,
  input  logic [3:0]                   digit,
  output logic                         match,
  output logic [$clog2(SEQ_LEN+1)-1:0] progress,
  output logic [CNT_W-1:0]             match_count,
  output logic                         bad_digit,
  output logic                         timeout
);

  localparam int PW = $clog2(SEQ_LEN + 1);

  logic [PW-1:0]    step_p;
  logic             step_hit;
  logic             expire;

  logic             nxt_match;
  logic [PW-1:0]    nxt_progress;
  logic [CNT_W-1:0] nxt_count;
  logic             nxt_bad;
  logic             nxt_timeout;

  bday_kmp_step #(
    .SEQ_LEN (SEQ_LEN),
    .SEQ     (SEQ)
  ) u_step (
    .p      (progress),
    .d      (digit),
    .next_p (step_p),
    .hit    (step_hit)
  );

`ifdef BDAY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] idle_cnt;

  // Fires on the TIMEOUT_CYC-th consecutive idle cycle while a partial match is held.
  assign expire = !digit_valid && (progress != '0) && (idle_cnt == TW'(TIMEOUT_CYC - 1));

  // Count idle cycles with a partial match pending; any valid digit or empty progress restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          idle_cnt <= '0;
    else if (digit_valid || progress == '0 || expire)   idle_cnt <= '0;
    else                                                idle_cnt <= idle_cnt + TW'(1);
  end
`else
  // Feature off: partial progress is held forever (comparison is constant false).
  assign expire = (TIMEOUT_CYC < 0);
`endif

  // Next-state: bad digit beats the KMP step; a valid digit beats an idle expiry.
  always_comb begin
    nxt_match    = 1'b0;
    nxt_progress = progress;
    nxt_count    = match_count;
    nxt_bad      = 1'b0;
    nxt_timeout  = 1'b0;
    if (digit_valid) begin
      if (digit > DIGIT_MAX) begin
        nxt_bad      = 1'b1;
        nxt_progress = '0;
      end else begin
        nxt_progress = step_p;
        if (step_hit) begin
          nxt_match = 1'b1;
          if (match_count != {CNT_W{1'b1}}) nxt_count = match_count + CNT_W'(1);
        end
      end
    end else if (expire) begin
      nxt_progress = '0;
      nxt_timeout  = 1'b1;
    end
  end

  // Output registers; reset drops any partial match immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match       <= 1'b0;
      progress    <= '0;
      match_count <= '0;
      bad_digit   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      match       <= nxt_match;
      progress    <= nxt_progress;
      match_count <= nxt_count;
      bad_digit   <= nxt_bad;
      timeout     <= nxt_timeout;
    end
  end

endmodule

// File: tb/tb_bday_seq_detector.sv
// Self-checking bench for bday_seq_detector: vector table plus hand-written multi-cycle cases.
// Inputs driven on the falling edge, outputs checked 1 time unit after the rising edge.
// Expected results are queued at drive time and popped when the registered outputs settle.
module tb_bday_seq_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       digit_valid;
  logic [3:0] digit;
  logic       match;
  logic [3:0] progress;
  logic [7:0] match_count;
  logic       bad_digit;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic m;
    int   p;
    int   c;
    logic b;
    logic t;
  } exp_t;

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       m;
    int         p;
    int         c;
    logic       b;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  int bseq[8]     = '{2, 0, 0, 2, 0, 9, 1, 5};
  int exp_prog[8] = '{1, 2, 3, 4, 5, 6, 7, 0};

  bday_seq_detector dut (
    .clk         (clk),
    .reset       (reset),
    .digit_valid (digit_valid),
    .digit       (digit),
    .match       (match),
    .progress    (progress),
    .match_count (match_count),
    .bad_digit   (bad_digit),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
    end else begin
      e = sb.pop_front();
      cmp("match",       32'(match),       32'(e.m));
      cmp("progress",    32'(progress),    32'(e.p));
      cmp("match_count", 32'(match_count), 32'(e.c));
      cmp("bad_digit",   32'(bad_digit),   32'(e.b));
      cmp("timeout",     32'(timeout),     32'(e.t));
    end
  endtask

  // One clock of stimulus; the expectation is queued now and checked after the edge.
  task automatic drive(input logic v, input logic [3:0] d, input logic m, input int p,
                       input int c, input logic b, input logic t);
    exp_t e;
    @(negedge clk);
    digit_valid = v;
    digit       = d;
    e.m = m; e.p = p; e.c = c; e.b = b; e.t = t;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    digit_valid = 1'b0;
    reset       = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic void add(input logic v, input logic [3:0] d, input logic m,
                              input int p, input int c, input logic b);
    vec_t r;
    r.v = v; r.d = d; r.m = m; r.p = p; r.c = c; r.b = b;
    tbl.push_back(r);
  endfunction

  initial begin
    // Basic sequence: match one cycle after the final 5.
    add(1, 2, 0, 1, 0, 0); add(1, 0, 0, 2, 0, 0); add(1, 0, 0, 3, 0, 0); add(1, 2, 0, 4, 0, 0);
    add(1, 0, 0, 5, 0, 0); add(1, 9, 0, 6, 0, 0); add(1, 1, 0, 7, 0, 0); add(1, 5, 1, 0, 1, 0);
    // Overlap: 6th digit drops progress 5 -> 3.
    add(1, 2, 0, 1, 1, 0); add(1, 0, 0, 2, 1, 0); add(1, 0, 0, 3, 1, 0); add(1, 2, 0, 4, 1, 0);
    add(1, 0, 0, 5, 1, 0); add(1, 0, 0, 3, 1, 0); add(1, 2, 0, 4, 1, 0); add(1, 0, 0, 5, 1, 0);
    add(1, 9, 0, 6, 1, 0); add(1, 1, 0, 7, 1, 0); add(1, 5, 1, 0, 2, 0);
    // Repeated first digit and a two-level fallback 4 -> 1 -> 0 -> 1.
    add(1, 2, 0, 1, 2, 0); add(1, 2, 0, 1, 2, 0); add(1, 0, 0, 2, 2, 0); add(1, 0, 0, 3, 2, 0);
    add(1, 2, 0, 4, 2, 0); add(1, 2, 0, 1, 2, 0);
    // Digit 9 (largest legal) mismatching at p=1 clears to 0 without bad_digit.
    add(1, 9, 0, 0, 2, 0);
    // Gaps of 3 idle cycles hold progress; digit lines carry junk while invalid.
    add(1, 2, 0, 1, 2, 0); add(0, 5, 0, 1, 2, 0); add(0, 5, 0, 1, 2, 0); add(0, 5, 0, 1, 2, 0);
    add(1, 0, 0, 2, 2, 0); add(0, 5, 0, 2, 2, 0); add(0, 5, 0, 2, 2, 0); add(0, 5, 0, 2, 2, 0);
    add(1, 0, 0, 3, 2, 0); add(0, 5, 0, 3, 2, 0); add(0, 5, 0, 3, 2, 0); add(0, 5, 0, 3, 2, 0);
    add(1, 2, 0, 4, 2, 0);
    // Illegal digit at progress 4, then boundary values 10 and 15.
    add(1, 12, 0, 0, 2, 1); add(0, 0, 0, 0, 2, 0);
    add(1, 10, 0, 0, 2, 1); add(1, 15, 0, 0, 2, 1); add(1, 2, 0, 1, 2, 0); add(1, 10, 0, 0, 2, 1);
    add(0, 0, 0, 0, 2, 0);

    reset       = 1'b1;
    digit_valid = 1'b0;
    digit       = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_match",    32'(match),       32'd0);
    cmp("reset_progress", 32'(progress),    32'd0);
    cmp("reset_count",    32'(match_count), 32'd0);
    cmp("reset_bad",      32'(bad_digit),   32'd0);
    cmp("reset_timeout",  32'(timeout),     32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i])
      drive(tbl[i].v, tbl[i].d, tbl[i].m, tbl[i].p, tbl[i].c, tbl[i].b, 1'b0);

    // Asynchronous reset mid-cycle at progress 6 with a non-zero count.
    do_reset();
    for (int j = 0; j < 8; j++) drive(1, 4'(bseq[j]), j == 7, exp_prog[j], (j == 7) ? 1 : 0, 0, 0);
    for (int j = 0; j < 6; j++) drive(1, 4'(bseq[j]), 0, exp_prog[j], 1, 0, 0);
    #2;
    digit_valid = 1'b0;
    reset       = 1'b1;
    #1;
    cmp("async_rst_progress", 32'(progress),    32'd0);
    cmp("async_rst_count",    32'(match_count), 32'd0);
    cmp("async_rst_match",    32'(match),       32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 8; j++) drive(1, 4'(bseq[j]), j == 7, exp_prog[j], (j == 7) ? 1 : 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);

    // 300 back-to-back matches: count saturates at 255, pulses continue.
    do_reset();
    for (int k = 1; k <= 300; k++)
      for (int j = 0; j < 8; j++)
        drive(1, 4'(bseq[j]), j == 7, exp_prog[j],
              (j == 7) ? ((k > 255) ? 255 : k) : ((k - 1 > 255) ? 255 : k - 1), 0, 0);
    drive(0, 0, 0, 0, 255, 0, 0);

    // Idle behaviour with a partial match of 3.
    do_reset();
    drive(1, 2, 0, 1, 0, 0, 0); drive(1, 0, 0, 2, 0, 0, 0); drive(1, 0, 0, 3, 0, 0, 0);
`ifdef BDAY_TIMEOUT_EN
    for (int i = 0; i < 15; i++) drive(0, 0, 0, 3, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    // A valid digit on the expiry cycle wins.
    drive(1, 2, 0, 1, 0, 0, 0); drive(1, 0, 0, 2, 0, 0, 0); drive(1, 0, 0, 3, 0, 0, 0);
    for (int i = 0; i < 15; i++) drive(0, 0, 0, 3, 0, 0, 0);
    drive(1, 2, 0, 4, 0, 0, 0);
    drive(0, 0, 0, 4, 0, 0, 0);
`else
    for (int i = 0; i < 100; i++) drive(0, 0, 0, 3, 0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
